// File: rtl/yoshi_hit_ctrl_pkg.sv
// Shared game definitions for the Yoshi hit controller: FSM encoding and
// frame-counter sizing.
package yoshi_hit_ctrl_pkg;

  localparam int FCNT_W = 8;

  typedef logic [FCNT_W-1:0] fcnt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HIT  = 2'd2,
    ST_OVER = 2'd3
  } hit_state_e;

  function automatic fcnt_t to_fcnt(input int v);
    return fcnt_t'(v);
  endfunction

endpackage

// File: rtl/yoshi_hit_ctrl_frame_down_counter.sv
// Loadable frame counter: counts frame_ticks down to 0 and holds there.
// Load wins over decrement; last flags the tick that will reach 0.
module frame_down_counter
  import yoshi_hit_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  fcnt_t load_val,
  input  logic  dec,
  output logic  zero,
  output logic  last
);

  fcnt_t cnt;

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
  assign last = (cnt == fcnt_t'(1));

endmodule

// File: rtl/yoshi_hit_ctrl.sv
// Turns frame-sampled collisions into life loss, a blinking invulnerability
// window and game-over handling for the Yoshi sprite.
module yoshi_hit_ctrl
  import yoshi_hit_ctrl_pkg::*;
#(
  parameter int LIVES         = 3,
  parameter int INVULN_FRAMES = 120,
  parameter int BLINK_FRAMES  = 8,
  parameter int OVER_FRAMES   = 180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       collision,
  input  logic       start,
  output logic [1:0] lives,
  output logic       hit,
  output logic       invuln,
  output logic       yoshi_visible,
  output logic       playing,
  output logic       game_over
);

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam fcnt_t      INV_LD     = to_fcnt(INVULN_FRAMES);
  localparam fcnt_t      BLK_LD     = to_fcnt(BLINK_FRAMES);
  localparam fcnt_t      OVR_LD     = to_fcnt(OVER_FRAMES);

  hit_state_e state;

  logic  f_zero, f_last, b_zero, b_last;
  logic  take_hit, hit_tick, inv_done, blink_wrap, restart, last_life;
  logic  f_load, f_dec, b_load, b_dec;
  fcnt_t f_val;

  assign last_life = (lives == 2'd1);
  assign take_hit  = (state == ST_PLAY) && frame_tick && collision;
  assign hit_tick  = (state == ST_HIT) && frame_tick;
  assign inv_done  = hit_tick && f_last;
  // Reload the blink period on expiry; b_zero only guards against a stale count.
  assign blink_wrap = hit_tick && (b_last || b_zero) && !inv_done;
  // In OVER the counter is judged before this cycle's decrement.
  assign restart = start && ((state == ST_IDLE) || ((state == ST_OVER) && f_zero));

  assign f_load = take_hit;
  assign f_val  = last_life ? OVR_LD : INV_LD;
  assign f_dec  = frame_tick && ((state == ST_HIT) || (state == ST_OVER));
  assign b_load = (take_hit && !last_life) || blink_wrap;
  assign b_dec  = hit_tick;

  frame_down_counter u_frame_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (f_load),
    .load_val (f_val),
    .dec      (f_dec),
    .zero     (f_zero),
    .last     (f_last)
  );

  frame_down_counter u_blink_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (b_load),
    .load_val (BLK_LD),
    .dec      (b_dec),
    .zero     (b_zero),
    .last     (b_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      lives         <= LIVES_INIT;
      hit           <= 1'b0;
      yoshi_visible <= 1'b1;
    end else begin
      hit <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (restart) begin
            state <= ST_PLAY;
            lives <= LIVES_INIT;
          end
        end
        ST_PLAY: begin
          if (take_hit) begin
            hit   <= 1'b1;
            lives <= lives - 2'd1;
            if (last_life) begin
              state <= ST_OVER;
            end else begin
              state         <= ST_HIT;
              yoshi_visible <= 1'b0;
            end
          end
        end
        ST_HIT: begin
          if (inv_done) begin
            state         <= ST_PLAY;
            yoshi_visible <= 1'b1;
          end else if (blink_wrap) begin
            yoshi_visible <= ~yoshi_visible;
          end
        end
        ST_OVER: begin
          if (restart) begin
            state         <= ST_PLAY;
            lives         <= LIVES_INIT;
            yoshi_visible <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign invuln    = (state == ST_HIT);
  assign playing   = (state == ST_PLAY) || (state == ST_HIT);
  assign game_over = (state == ST_OVER);

endmodule

// File: tb/tb_yoshi_hit_ctrl.sv
// Scoreboard bench for yoshi_hit_ctrl: directed game scenarios followed by
// random tick/collision/start streams against a frame-count reference model.
module tb_yoshi_hit_ctrl;

  localparam int LV  = 3;
  localparam int INV = 4;
  localparam int BLK = 2;
  localparam int OVR = 3;

  logic       clk = 1'b0;
  logic       reset, frame_tick, collision, start;
  logic [1:0] lives;
  logic       hit, invuln, yoshi_visible, playing, game_over;

  yoshi_hit_ctrl #(
    .LIVES(LV), .INVULN_FRAMES(INV), .BLINK_FRAMES(BLK), .OVER_FRAMES(OVR)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .collision     (collision),
    .start         (start),
    .lives         (lives),
    .hit           (hit),
    .invuln        (invuln),
    .yoshi_visible (yoshi_visible),
    .playing       (playing),
    .game_over     (game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lives;
    bit hit, invuln, vis, playing, over;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: game phase plus frames elapsed since the last hit / game over.
  typedef enum {M_IDLE, M_PLAY, M_HIT, M_OVER} mmode_e;
  mmode_e m_mode = M_IDLE;
  int     m_lives = LV, m_since_hit = 0, m_since_over = 0;
  bit     m_hit = 0;

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", nm, $time, got, exp);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.lives   = m_lives;
    e.hit     = m_hit;
    e.invuln  = (m_mode == M_HIT);
    e.vis     = (m_mode == M_HIT) ? (((m_since_hit / BLK) % 2) == 1) : 1'b1;
    e.playing = (m_mode == M_PLAY) || (m_mode == M_HIT);
    e.over    = (m_mode == M_OVER);
    return e;
  endfunction

  task automatic model_step(input bit rst, input bit tk, input bit col, input bit st);
    if (rst) begin
      m_mode = M_IDLE; m_lives = LV; m_hit = 0; m_since_hit = 0; m_since_over = 0;
    end else begin
      m_hit = 0;
      case (m_mode)
        M_IDLE: if (st) begin m_mode = M_PLAY; m_lives = LV; end
        M_PLAY: if (tk && col) begin
          m_hit = 1;
          m_lives = m_lives - 1;
          if (m_lives == 0) begin m_mode = M_OVER; m_since_over = 0; end
          else begin m_mode = M_HIT; m_since_hit = 0; end
        end
        M_HIT: if (tk) begin
          m_since_hit++;
          if (m_since_hit >= INV) m_mode = M_PLAY;
        end
        M_OVER: begin
          if (st && m_since_over >= OVR) begin m_mode = M_PLAY; m_lives = LV; end
          else if (tk) m_since_over++;
        end
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  task automatic step(input bit rst, input bit tk, input bit col, input bit st);
    reset = rst; frame_tick = tk; collision = col; start = st;
    model_step(rst, tk, col, st);
    @(posedge clk);
    sbq.push_back(model_out());
    #1;
  endtask

  task automatic ticks(input int n, input bit col);
    for (int i = 0; i < n; i++) begin
      step(0, 0, col, 0);
      step(0, 1, col, 0);
    end
  endtask

  // Monitor: previous-edge inputs feed the structural property checks.
  logic tick_d, start_d, rst_d, prev_hit = 1'b0;
  int   prev_lives = -1;

  always @(posedge clk) begin
    tick_d  <= frame_tick;
    start_d <= start;
    rst_d   <= reset;
  end

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("lives",     int'(lives),         e.lives);
      check("hit",       int'(hit),           int'(e.hit));
      check("invuln",    int'(invuln),        int'(e.invuln));
      check("visible",   int'(yoshi_visible), int'(e.vis));
      check("playing",   int'(playing),       int'(e.playing));
      check("game_over", int'(game_over),     int'(e.over));
      if (hit === 1'b1) begin
        check("hit_after_tick", int'(tick_d), 1);
        check("hit_one_cycle",  int'(prev_hit), 0);
      end
      if (prev_lives >= 0 && rst_d === 1'b0 && start_d === 1'b0)
        check("lives_no_increase", int'(int'(lives) > prev_lives), 0);
      prev_lives = int'(lives);
      prev_hit   = hit;
    end
  end

  initial begin
    reset = 1'b1; frame_tick = 1'b0; collision = 1'b0; start = 1'b0;
    step(1, 0, 0, 0);
    step(1, 1, 1, 1);
    // IDLE ignores collision
    step(0, 1, 1, 0);
    step(0, 0, 0, 1);
    // collision without a frame tick is never sampled
    repeat (3) step(0, 0, 1, 0);
    // first hit, then collision held through the whole window
    step(0, 1, 1, 0);
    ticks(INV, 1'b1);
    step(0, 0, 0, 0);
    // second hit, wait out, third hit -> game over
    ticks(1, 1'b1);
    ticks(INV + 1, 1'b0);
    step(0, 1, 1, 0);
    // start ignored while the over counter runs, incl. on the zeroing tick
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    // start + tick + collision coincident in IDLE
    step(1, 0, 0, 0);
    step(0, 1, 1, 1);
    step(0, 0, 0, 0);
    // reset two ticks into HIT
    step(0, 1, 1, 0);
    ticks(2, 1'b0);
    step(1, 1, 1, 0);
    step(0, 0, 0, 0);
    // reset mid-OVER
    step(0, 0, 0, 1);
    for (int h = 0; h < LV; h++) begin
      step(0, 1, 1, 0);
      ticks(INV, 1'b0);
    end
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    // random streams
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 399) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 11) == 0);
    end
    step(0, 0, 0, 0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
